// File: rtl/if_stage.sv
// ============================================================================
// if_stage
// Instruction-fetch stage sitting directly in front of the instruction memory.
// Owns the word-addressed program counter, drives the combinational memory
// read address, and captures the returned word into the IF/ID pipeline
// register. Handles hazard stalls, downstream branch/jump redirects and the
// end-of-code halt condition.
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'd31,
    parameter logic [31:0] PC_MAX   = 32'd223,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        halted,
    output logic        addr_err,
    output logic [31:0] fetch_count
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // A redirect target is legal only inside the code region of the memory.
    function automatic logic in_code_range(input logic [31:0] addr);
        return (addr >= RESET_PC) && (addr <= PC_MAX);
    endfunction

    // ------------------------------------------------------------------------
    // State and pipeline registers
    // ------------------------------------------------------------------------
    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] if_id_instr_r;
    logic [31:0] if_id_pc_r;
    logic        if_id_valid_r;
    logic        addr_err_r;
    logic [31:0] fetch_count_r;

    // Next-state values computed by the combinational process
    state_t      state_nxt_s;
    logic [31:0] pc_nxt_s;
    logic [31:0] if_id_instr_nxt_s;
    logic [31:0] if_id_pc_nxt_s;
    logic        if_id_valid_nxt_s;
    logic        addr_err_nxt_s;
    logic [31:0] fetch_count_nxt_s;
    logic        target_ok_s;

    // Next-state and datapath decisions; priority is redirect > stall > fetch.
    always_comb begin
        state_nxt_s       = state_r;
        pc_nxt_s          = pc_r;
        if_id_instr_nxt_s = if_id_instr_r;
        if_id_pc_nxt_s    = if_id_pc_r;
        if_id_valid_nxt_s = if_id_valid_r;
        addr_err_nxt_s    = addr_err_r;
        fetch_count_nxt_s = fetch_count_r;
        target_ok_s       = in_code_range(redirect_pc);

        case (state_r)
            ST_RUN: begin
                if (redirect_valid) begin
                    // Flush IF/ID; an illegal target is still loaded into
                    // the PC so it stays visible for debug.
                    pc_nxt_s          = redirect_pc;
                    if_id_instr_nxt_s = NOP;
                    if_id_valid_nxt_s = 1'b0;
                    if (target_ok_s) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s    = ST_HALT;
                        addr_err_nxt_s = 1'b1;
                    end
                end else if (stall) begin
                    // Hold everything while the hazard unit holds us.
                    state_nxt_s = ST_RUN;
                end else begin
                    if_id_instr_nxt_s = imem_data;
                    if_id_pc_nxt_s    = pc_r;
                    if_id_valid_nxt_s = 1'b1;
                    fetch_count_nxt_s = fetch_count_r + 32'd1;
                    if (pc_r == PC_MAX) begin
                        // Last code word fetched: run off the end and stop.
                        state_nxt_s = ST_HALT;
                        pc_nxt_s    = PC_MAX + 32'd1;
                    end else begin
                        state_nxt_s = ST_RUN;
                        pc_nxt_s    = pc_r + 32'd1;
                    end
                end
            end

            ST_HALT: begin
                if (redirect_valid) begin
                    // A late branch can pull fetch back into the code region.
                    pc_nxt_s          = redirect_pc;
                    if_id_instr_nxt_s = NOP;
                    if_id_valid_nxt_s = 1'b0;
                    if (target_ok_s) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s    = ST_HALT;
                        addr_err_nxt_s = 1'b1;
                    end
                end else if (stall) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    // Keep emitting bubbles while halted.
                    state_nxt_s       = ST_HALT;
                    if_id_instr_nxt_s = NOP;
                    if_id_valid_nxt_s = 1'b0;
                end
            end

            default: begin
                // Unreachable encoding: park safely with a bubble.
                state_nxt_s       = ST_HALT;
                if_id_instr_nxt_s = NOP;
                if_id_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // PC, IF/ID pipeline register, sticky error flag and fetch counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            if_id_instr_r <= NOP;
            if_id_pc_r    <= 32'd0;
            if_id_valid_r <= 1'b0;
            addr_err_r    <= 1'b0;
            fetch_count_r <= 32'd0;
        end else begin
            pc_r          <= pc_nxt_s;
            if_id_instr_r <= if_id_instr_nxt_s;
            if_id_pc_r    <= if_id_pc_nxt_s;
            if_id_valid_r <= if_id_valid_nxt_s;
            addr_err_r    <= addr_err_nxt_s;
            fetch_count_r <= fetch_count_nxt_s;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: all come straight from registers
    // ------------------------------------------------------------------------
    assign imem_addr   = pc_r;
    assign if_id_instr = if_id_instr_r;
    assign if_id_pc    = if_id_pc_r;
    assign if_id_valid = if_id_valid_r;
    assign halted      = (state_r == ST_HALT);
    assign addr_err    = addr_err_r;
    assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_if_stage.sv
// ============================================================================
// tb_if_stage
// Directed bench for if_stage. A 256-word memory holds a recognisable word at
// every address; expected values are written out by hand per step.
// ============================================================================
`timescale 1ns/1ps
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;
    logic        addr_err;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:255];
    int          n_checks;
    int          n_fail;

    if_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .addr_err       (addr_err),
        .fetch_count    (fetch_count)
    );

    // Zero-latency instruction memory; addresses past the array read as 0.
    assign imem_data = (imem_addr < 32'd256) ? mem[imem_addr[7:0]] : 32'h0;

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word stored at a given address.
    function automatic logic [31:0] w(input int a);
        return 32'hC0DE_0000 ^ 32'(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr,
                              input logic [31:0] pc, input logic valid);
        check({tag, ".instr"}, if_id_instr, instr);
        check({tag, ".pc"},    if_id_pc,    pc);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".instr"},  if_id_instr, 32'h0);
        check({tag, ".ifpc"},   if_id_pc,    32'd0);
        check({tag, ".valid"},  {31'd0, if_id_valid}, 32'd0);
        check({tag, ".halted"}, {31'd0, halted},      32'd0);
        check({tag, ".aerr"},   {31'd0, addr_err},    32'd0);
        check({tag, ".count"},  fetch_count, 32'd0);
        check({tag, ".addr"},   imem_addr,   32'd31);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) mem[i] = w(i);
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;

        // First fetch
        step();
        check_ifid("f1", w(31), 32'd31, 1'b1);
        check("f1.count", fetch_count, 32'd1);
        check("f1.addr",  imem_addr,   32'd32);

        // Two stalled edges hold everything
        stall = 1'b1;
        step();
        step();
        check_ifid("stl", w(31), 32'd31, 1'b1);
        check("stl.addr",  imem_addr,   32'd32);
        check("stl.count", fetch_count, 32'd1);
        stall = 1'b0;
        step();
        check_ifid("f2", w(32), 32'd32, 1'b1);
        step();
        check_ifid("f3", w(33), 32'd33, 1'b1);
        check("f3.count", fetch_count, 32'd3);

        // Redirect wins over stall: one bubble, then the target
        redirect_valid = 1'b1;
        redirect_pc    = 32'd40;
        stall          = 1'b1;
        step();
        check("rd.valid", {31'd0, if_id_valid}, 32'd0);
        check("rd.instr", if_id_instr, 32'h0);
        check("rd.addr",  imem_addr,   32'd40);
        check("rd.count", fetch_count, 32'd3);
        redirect_valid = 1'b0;
        stall          = 1'b0;
        step();
        check_ifid("rd40", w(40), 32'd40, 1'b1);
        check("rd40.count", fetch_count, 32'd4);

        // Run off the end of the code region
        redirect_valid = 1'b1;
        redirect_pc    = 32'd220;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        step();
        check_ifid("f222", w(222), 32'd222, 1'b1);
        check("f222.halted", {31'd0, halted}, 32'd0);
        step();
        check_ifid("f223", w(223), 32'd223, 1'b1);
        check("f223.halted", {31'd0, halted}, 32'd1);
        check("f223.count",  fetch_count, 32'd8);
        check("f223.addr",   imem_addr,   32'd224);
        step();
        check("h1.valid",  {31'd0, if_id_valid}, 32'd0);
        check("h1.instr",  if_id_instr, 32'h0);
        check("h1.count",  fetch_count, 32'd8);
        check("h1.addr",   imem_addr,   32'd224);
        check("h1.halted", {31'd0, halted}, 32'd1);

        // Redirect out of halt
        redirect_valid = 1'b1;
        redirect_pc    = 32'd100;
        step();
        check("rh.halted", {31'd0, halted}, 32'd0);
        check("rh.addr",   imem_addr,   32'd100);
        redirect_valid = 1'b0;
        step();
        check_ifid("f100", w(100), 32'd100, 1'b1);
        check("f100.count", fetch_count, 32'd9);

        // Illegal target below the code region
        redirect_valid = 1'b1;
        redirect_pc    = 32'd5;
        step();
        check("lo.aerr",   {31'd0, addr_err}, 32'd1);
        check("lo.halted", {31'd0, halted},   32'd1);
        check("lo.addr",   imem_addr,   32'd5);
        check("lo.valid",  {31'd0, if_id_valid}, 32'd0);
        redirect_valid = 1'b0;
        step();
        check("lo2.addr",  imem_addr,   32'd5);
        check("lo2.count", fetch_count, 32'd9);

        // Legal redirect clears halt but not the sticky error
        redirect_valid = 1'b1;
        redirect_pc    = 32'd60;
        step();
        check("rc.halted", {31'd0, halted},   32'd0);
        check("rc.aerr",   {31'd0, addr_err}, 32'd1);
        redirect_valid = 1'b0;
        step();
        check_ifid("f60", w(60), 32'd60, 1'b1);
        check("f60.count", fetch_count, 32'd10);

        // Illegal target above the code region
        redirect_valid = 1'b1;
        redirect_pc    = 32'd250;
        step();
        check("hi.aerr",   {31'd0, addr_err}, 32'd1);
        check("hi.halted", {31'd0, halted},   32'd1);
        check("hi.addr",   imem_addr,   32'd250);
        redirect_pc    = 32'd31;
        step();
        check("hi2.halted", {31'd0, halted},   32'd0);
        check("hi2.aerr",   {31'd0, addr_err}, 32'd1);
        redirect_valid = 1'b0;
        step();
        check_ifid("f31b", w(31), 32'd31, 1'b1);
        check("f31b.count", fetch_count, 32'd11);
        step();
        check_ifid("f32b", w(32), 32'd32, 1'b1);
        check("f32b.count", fetch_count, 32'd12);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_ifid("ra", w(31), 32'd31, 1'b1);
        check("ra.count", fetch_count, 32'd1);
        check("ra.aerr",  {31'd0, addr_err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage directly upstream of the instruction memory `im`. The block owns the word-addressed program counter and drives the memory's combinational read address. It captures the returned word into the IF/ID pipeline register for decode. It also handles hazard-unit stalls, branch/jump redirects from later stages, and the end-of-code halt condition for the memory's code region.

## Interface
- `RESET_PC`, 31: first code word; the start of the code region in `im`.
- `PC_MAX`, 223: last valid code word, equal to MEM_SIZE-33 for MEM_SIZE=256.
- `NOP`, 32'h0000_0000: word inserted into IF/ID when no valid instruction is present.
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `stall` input 1: hazard unit requests a hold of PC and IF/ID.
- `redirect_valid` input 1: a taken branch/jump has resolved downstream.
- `redirect_pc` input 32: target word address for the redirect.
- `imem_addr` output 32: read address to `im`; always equal to `pc`.
- `imem_data` input 32: combinational read data from `im`.
- `if_id_instr` output 32: registered instruction.
- `if_id_pc` output 32: word address of `if_id_instr`.
- `if_id_valid` output 1: `if_id_instr` is a real instruction, not a bubble.
- `halted` output 1: fetch has stopped; PC is past `PC_MAX` or a redirect target was illegal.
- `addr_err` output 1: sticky flag, set by an out-of-range redirect target.
- `fetch_count` output 32: number of valid instructions delivered to IF/ID.

## Operation
- The state machine has two states, RUN and HALT. The PC is a 32-bit register and advances by 1 per fetch (word addressing, no byte offset).
- `imem_addr = pc` combinationally in both states. The memory has zero read latency, so `imem_data` is sampled on the same edge.
- Per-edge priority is: reset > redirect > stall > normal.
- RUN, `redirect_valid`=1 with `RESET_PC` ≤ `redirect_pc` ≤ `PC_MAX`:
  - `pc` ← `redirect_pc`.
  - IF/ID is flushed: `if_id_valid` ← 0 and `if_id_instr` ← `NOP`.
  - `stall` is ignored on this edge.
- RUN, `redirect_valid`=1 with the target out of range:
  - `addr_err` ← 1 and the state goes to HALT.
  - IF/ID is flushed and `pc` ← `redirect_pc`, so the illegal address stays visible.
- RUN, `stall`=1 and no redirect: `pc`, all IF/ID fields and `fetch_count` hold.
- RUN, normal edge:
  - `if_id_instr` ← `imem_data`, `if_id_pc` ← `pc`, `if_id_valid` ← 1.
  - `fetch_count` ← `fetch_count` + 1.
  - If `pc` == `PC_MAX`, the next state is HALT and `pc` ← `PC_MAX`+1. Otherwise `pc` ← `pc`+1.
- HALT:
  - `halted`=1.
  - On each non-stalled edge, `if_id_valid` ← 0 and `if_id_instr` ← `NOP`.
  - `pc` holds and `fetch_count` holds.
- HALT with an in-range redirect: return to RUN with `pc` ← `redirect_pc`.
  - This covers a branch in the last code word that resolves after fetch has run off the end.
  - `addr_err` stays set once set; only reset clears it.
- HALT with an out-of-range redirect: stay in HALT and set `addr_err`.
- `fetch_count` wraps modulo 2^32.

## Timing
- Reset values, applied asynchronously while `rst_n`=0:
  - state RUN, `pc`=`RESET_PC`, `if_id_instr`=`NOP`, `if_id_pc`=0.
  - `if_id_valid`=0, `halted`=0, `addr_err`=0, `fetch_count`=0.
- After `rst_n` is released, the first rising edge loads mem[`RESET_PC`] into IF/ID with `if_id_valid`=1.
- Fetch latency is 1 cycle from PC to IF/ID. Throughput is 1 instruction per cycle when not stalled.
- Redirect penalty is 1 bubble: the edge that accepts the redirect emits a bubble, and the next edge delivers the target instruction.
- `halted` is registered. It rises on the edge that fetches `PC_MAX` and falls on the edge that accepts an in-range redirect.
- `rst_n` asserted mid-run or mid-stall forces reset values immediately. No partial update survives.

## Test plan
- Reset then free-run with mem[31..33]=A,B,C: after edge 1 IF/ID is (A, pc 31, valid 1); after edges 2 and 3 it is (B, 32) then (C, 33); `fetch_count`=3.
- `stall` high for 2 cycles after edge 1: IF/ID holds (A, 31), `pc` holds 32, `fetch_count` holds 1; B follows on the first unstalled edge.
- `redirect_valid`=1 with `redirect_pc`=40, asserted together with `stall`=1 on the same edge: result is a bubble (valid 0, instr 0); on the next edge IF/ID is (mem[40], 40).
- Run to `PC_MAX`=223: the edge that fetches 223 delivers it with valid 1 and raises `halted`; later edges give valid 0 with `fetch_count` frozen. A redirect to 100 then resumes fetch from 100.
- Redirect to 5, then separately to 250: `addr_err`=1 and `halted`=1 in each case, and `pc` shows the illegal target. A later in-range redirect clears `halted` but `addr_err` stays 1.
- Assert `rst_n`=0 asynchronously between edges mid-run: all outputs take reset values without waiting for a clock edge, and fetch restarts at 31.
